fsmc_sample_reader: RTL and testbench
=====================================

# fsmc_sample_reader

Parametrised capture-and-readout buffer between the ADC sample stream and the STM32 FSMC data bus. It supersedes the fixed-table FSMC responder. A synchronised START edge captures DEPTH frames of CHANNELS samples into on-chip RAM. The block then serves them to the MCU one 16-bit word per FSMC read strobe, channel-interleaved, optionally preceded by a header word. It sits in the DCLK domain between the ADC front-end and the FSMC pins.

## Interface
- DATA_W, 12, sample width in bits; must be ≤ BUS_W
- BUS_W, 16, FSMC data bus width
- DEPTH, 10000, frames captured per acquisition
- CHANNELS, 2, samples per frame (1..4)
- SIGN_EXT, 0, 0 = zero-extend samples to BUS_W; 1 = sign-extend
- HEADER_EN, 1, 1 = emit header word 16'hA55A before the first sample
- DCLK  in  1  sole clock; all logic on posedge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  acquisition request, asynchronous; rising edge acts
- SMP_DATA  in  CHANNELS*DATA_W  frame data, channel 0 in LSBs
- SMP_VALID  in  1  one-cycle strobe; frame accepted on this cycle
- FGPA_OE  in  1  FSMC NOE, active low, asynchronous
- FSMC_D  inout  BUS_W  driven only while READOUT and FGPA_OE low, else Z
- BUSY  out  1  high in CAPTURE or READOUT
- READY  out  1  high in READOUT
- OVERRUN  out  1  sticky; set when a START rising edge aborts an acquisition in progress

## Operation
- START and FGPA_OE each pass through a 2-flop synchroniser plus an edge register. Only synchronised versions are used.
- States: IDLE, CAPTURE, READOUT.
- IDLE: on a START rising edge → CAPTURE with wr_frame = 0.
- CAPTURE: each SMP_VALID writes all CHANNELS samples at wr_frame, then increments wr_frame. The write at wr_frame = DEPTH-1 → READOUT. SMP_VALID is ignored outside CAPTURE.
- READOUT word sequence: optional header, then frame 0 ch0, ch1, …, ch(CHANNELS-1), frame 1 ch0, …
- Total words per acquisition: DEPTH*CHANNELS + HEADER_EN.
- A synchronised OE rising edge (end of the read strobe) advances the read pointer. Channel index wraps to 0 and increments the frame index.
- After the final word's OE rising edge → IDLE. READY drops; FSMC_D releases.
- A START rising edge in CAPTURE or READOUT sets OVERRUN, discards the current acquisition and re-enters CAPTURE with wr_frame = 0.
- If a START edge and SMP_VALID occur in the same cycle, START wins and that frame is not written.
- OVERRUN is cleared only by RST_N, or by a START rising edge seen in IDLE.
- Sample extension to BUS_W follows SIGN_EXT. Unused upper bits are 0 or copies of the sample MSB.
- Counter widths: $clog2(DEPTH) for frames and $clog2(CHANNELS) for channels, with no overflow beyond these terminal counts.
- OE edges in IDLE and CAPTURE are ignored. FSMC_D stays Z in those states.
- Mid-operation reset: all state is lost, outputs go to reset values, and RAM contents become don't-care.

## Timing
- Reset values: BUSY 0, READY 0, OVERRUN 0, FSMC_D Z, state IDLE, all counters 0.
- START to CAPTURE: BUSY rises 3 DCLK after START rises (2 sync + 1 edge).
- Capture-to-READOUT: READY rises the cycle after the last SMP_VALID. The first word is valid on the output register within 2 DCLK after that.
- Read pointer advance: the next word is stable on the output register 2 DCLK after the synchronised OE rising edge, i.e. ≤ 5 DCLK after the pin rises.
- FSMC timing required of the MCU: OE high ≥ 6 DCLK between reads and OE low ≥ 4 DCLK.
- Output word is registered and held constant while OE is low.
- Tri-state enable is combinational from the FGPA_OE pin and READY, with no sync delay.
- RAM: single write port and one registered read port; read latency 1 DCLK.

## Test plan
- **Basic capture and readout.** DEPTH=4, CHANNELS=2, HEADER_EN=1, frames {1,2},{3,4},{5,6},{7,8}, then 9 OE strobes → words A55A,1,2,3,4,5,6,7,8. READY falls after the 9th strobe and FSMC_D is Z afterwards.
- **Sign extension.** SIGN_EXT=1, DATA_W=12, sample 12'h800 → read 16'hF800. With SIGN_EXT=0 → 16'h0800.
- **Restart during readout.** START rising edge after 3 reads → OVERRUN=1, READY=0, BUSY=1 (CAPTURE). A fresh capture then reads from the header again. The next START in IDLE clears OVERRUN.
- **Simultaneous START and SMP_VALID.** Both in the same cycle during CAPTURE → that frame is not stored. The counter restarts at 0, so the next valid frame becomes frame 0.
- **Ignored strobes.** OE strobes in IDLE and CAPTURE, and SMP_VALID in READOUT → no pointer change, FSMC_D Z outside READOUT, RAM unchanged.
- **Async reset.** RST_N pulsed low mid-CAPTURE, asynchronous to DCLK → BUSY, READY and OVERRUN go 0 immediately and FSMC_D goes Z. After release, a START capture runs normally.

Source files
------------

// File: rtl/fsmc_sample_reader.sv
// ---------------------------------------------------------------------------
// fsmc_sample_reader
//
// Capture-and-readout buffer between the ADC sample stream and the STM32
// FSMC data bus. A synchronised START rising edge captures DEPTH frames of
// CHANNELS samples into on-chip RAM. The frames are then served to the MCU
// one BUS_W-bit word per FSMC read strobe. Words are channel-interleaved and
// optionally preceded by the header word 16'hA55A.
//
// Ports
//   DCLK       in     sole clock, all logic on posedge
//   RST_N      in     asynchronous active-low reset
//   START      in     acquisition request (asynchronous, rising edge acts)
//   SMP_DATA   in     CHANNELS*DATA_W frame, channel 0 in the LSBs
//   SMP_VALID  in     one-cycle frame strobe
//   FGPA_OE    in     FSMC NOE (active low, asynchronous)
//   FSMC_D     inout  data bus; driven only in READOUT while FGPA_OE is low
//   BUSY       out    high in CAPTURE or READOUT
//   READY      out    high in READOUT
//   OVERRUN    out    sticky; a START edge aborted an acquisition
// ---------------------------------------------------------------------------
module fsmc_sample_reader #(
    parameter int DATA_W    = 12,
    parameter int BUS_W     = 16,
    parameter int DEPTH     = 10000,
    parameter int CHANNELS  = 2,
    parameter int SIGN_EXT  = 0,
    parameter int HEADER_EN = 1
) (
    input  logic                         DCLK,
    input  logic                         RST_N,
    input  logic                         START,
    input  logic [CHANNELS*DATA_W-1:0]   SMP_DATA,
    input  logic                         SMP_VALID,
    input  logic                         FGPA_OE,
    inout  wire  [BUS_W-1:0]             FSMC_D,
    output logic                         BUSY,
    output logic                         READY,
    output logic                         OVERRUN
);

    localparam int FRM_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [BUS_W-1:0] HEADER_WORD = BUS_W'(16'hA55A);
    // Bits above the sample width; zero when DATA_W == BUS_W.
    localparam logic [BUS_W-1:0] EXT_MASK = {BUS_W{1'b1}} << DATA_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_READOUT = 2'd2
    } state_t;

    // Widen one sample to the bus width, zero- or sign-extending.
    function automatic logic [BUS_W-1:0] extend_sample(input logic signed [DATA_W-1:0] s);
        logic [BUS_W-1:0] w;
        w = BUS_W'(unsigned'(s));
        if ((SIGN_EXT != 0) && s[DATA_W-1]) begin
            w = w | EXT_MASK;
        end
        return w;
    endfunction

    state_t                       r_state;
    logic                         r_busy;
    logic                         r_ready;
    logic                         r_overrun;
    logic [FRM_W-1:0]             r_wr_frame;
    logic [FRM_W-1:0]             r_rd_frame;
    logic [CH_W-1:0]              r_rd_ch;
    logic                         r_rd_hdr;

    logic                         r_start_s1, r_start_s2, r_start_d;
    logic                         r_oe_s1, r_oe_s2, r_oe_d;

    logic [CHANNELS*DATA_W-1:0]   r_mem [DEPTH];
    logic [CHANNELS*DATA_W-1:0]   r_ram_q_p1;
    logic [BUS_W-1:0]             r_dout_p2;

    logic                         w_start_rise;
    logic                         w_oe_rise;
    logic                         w_we;
    logic signed [DATA_W-1:0]     w_sample;

    // Synchronisers: 2 flops plus an edge register for each async input.
    // OE idles high, so its chain resets high to avoid a spurious edge.
    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_start_s1 <= 1'b0;
            r_start_s2 <= 1'b0;
            r_start_d  <= 1'b0;
            r_oe_s1    <= 1'b1;
            r_oe_s2    <= 1'b1;
            r_oe_d     <= 1'b1;
        end else begin
            r_start_s1 <= START;
            r_start_s2 <= r_start_s1;
            r_start_d  <= r_start_s2;
            r_oe_s1    <= FGPA_OE;
            r_oe_s2    <= r_oe_s1;
            r_oe_d     <= r_oe_s2;
        end
    end

    assign w_start_rise = r_start_s2 & ~r_start_d;
    assign w_oe_rise    = r_oe_s2 & ~r_oe_d;

    // A START edge takes priority over a frame strobe in the same cycle.
    assign w_we = (r_state == S_CAPTURE) && SMP_VALID && !w_start_rise;

    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_overrun  <= 1'b0;
            r_wr_frame <= '0;
            r_rd_frame <= '0;
            r_rd_ch    <= '0;
            r_rd_hdr   <= 1'b0;
        end else if (w_start_rise) begin
            // Restart from any state; aborting a live acquisition is flagged,
            // a fresh start from IDLE clears the flag.
            r_overrun  <= (r_state != S_IDLE);
            r_state    <= S_CAPTURE;
            r_busy     <= 1'b1;
            r_ready    <= 1'b0;
            r_wr_frame <= '0;
            r_rd_frame <= '0;
            r_rd_ch    <= '0;
            r_rd_hdr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
                S_CAPTURE: begin
                    if (SMP_VALID) begin
                        if (r_wr_frame == FRM_W'(DEPTH - 1)) begin
                            r_state    <= S_READOUT;
                            r_ready    <= 1'b1;
                            r_rd_frame <= '0;
                            r_rd_ch    <= '0;
                            r_rd_hdr   <= (HEADER_EN != 0);
                        end else begin
                            r_wr_frame <= r_wr_frame + FRM_W'(1);
                        end
                    end
                end
                S_READOUT: begin
                    // Advance on the end of the read strobe.
                    if (w_oe_rise) begin
                        if (r_rd_hdr) begin
                            r_rd_hdr <= 1'b0;
                        end else if (r_rd_ch == CH_W'(CHANNELS - 1)) begin
                            r_rd_ch <= '0;
                            if (r_rd_frame == FRM_W'(DEPTH - 1)) begin
                                r_state    <= S_IDLE;
                                r_busy     <= 1'b0;
                                r_ready    <= 1'b0;
                                r_rd_frame <= '0;
                            end else begin
                                r_rd_frame <= r_rd_frame + FRM_W'(1);
                            end
                        end else begin
                            r_rd_ch <= r_rd_ch + CH_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Stage p1: frame RAM, single write port and registered read port.
    always_ff @(posedge DCLK) begin
        if (w_we) begin
            r_mem[r_wr_frame] <= SMP_DATA;
        end
        r_ram_q_p1 <= r_mem[r_rd_frame];
    end

    always_comb begin
        w_sample = r_ram_q_p1[DATA_W-1:0];
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_rd_ch == CH_W'(c)) begin
                w_sample = r_ram_q_p1[c*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p2: output word register. It only changes after a pointer move,
    // which the MCU's OE-high time covers, so it is stable while OE is low.
    always_ff @(posedge DCLK) begin
        r_dout_p2 <= r_rd_hdr ? HEADER_WORD : extend_sample(w_sample);
    end

    // Tri-state enable straight from the pin so the bus turns on/off without
    // synchroniser delay.
    assign FSMC_D  = (r_ready && !FGPA_OE) ? r_dout_p2 : {BUS_W{1'bz}};

    assign BUSY    = r_busy;
    assign READY   = r_ready;
    assign OVERRUN = r_overrun;

endmodule

// File: tb/tb_fsmc_sample_reader.sv
// ---------------------------------------------------------------------------
// Bench for fsmc_sample_reader. Two instances share every input: one
// zero-extends samples, one sign-extends. Expected bus words are queued as
// frames are driven and popped on each FSMC read strobe.
// ---------------------------------------------------------------------------
module tb_fsmc_sample_reader;

    localparam int DATA_W = 12;
    localparam int BUS_W  = 16;
    localparam int DEPTH  = 4;
    localparam int CH     = 2;

    logic                  DCLK;
    logic                  RST_N;
    logic                  START;
    logic [CH*DATA_W-1:0]  SMP_DATA;
    logic                  SMP_VALID;
    logic                  FGPA_OE;
    wire  [BUS_W-1:0]      fsmc_d_zx;
    wire  [BUS_W-1:0]      fsmc_d_sx;
    logic                  busy_zx, ready_zx, ovr_zx;
    logic                  busy_sx, ready_sx, ovr_sx;

    logic [BUS_W-1:0]      q_zx[$];
    logic [BUS_W-1:0]      q_sx[$];
    int                    n_cmp;
    int                    n_mis;

    fsmc_sample_reader #(
        .DATA_W(DATA_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .CHANNELS(CH),
        .SIGN_EXT(0), .HEADER_EN(1)
    ) u_dut_zx (
        .DCLK(DCLK), .RST_N(RST_N), .START(START), .SMP_DATA(SMP_DATA),
        .SMP_VALID(SMP_VALID), .FGPA_OE(FGPA_OE), .FSMC_D(fsmc_d_zx),
        .BUSY(busy_zx), .READY(ready_zx), .OVERRUN(ovr_zx)
    );

    fsmc_sample_reader #(
        .DATA_W(DATA_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .CHANNELS(CH),
        .SIGN_EXT(1), .HEADER_EN(1)
    ) u_dut_sx (
        .DCLK(DCLK), .RST_N(RST_N), .START(START), .SMP_DATA(SMP_DATA),
        .SMP_VALID(SMP_VALID), .FGPA_OE(FGPA_OE), .FSMC_D(fsmc_d_sx),
        .BUSY(busy_sx), .READY(ready_sx), .OVERRUN(ovr_sx)
    );

    initial DCLK = 1'b0;
    always #5 DCLK = ~DCLK;

    function automatic logic [BUS_W-1:0] ext(input logic [DATA_W-1:0] s, input bit sgn);
        return sgn ? {{(BUS_W-DATA_W){s[DATA_W-1]}}, s} : {{(BUS_W-DATA_W){1'b0}}, s};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge DCLK);
    endtask

    task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic b, input logic r, input logic o);
        chk({tag, "_busy_zx"},  16'(busy_zx),  16'(b));
        chk({tag, "_ready_zx"}, 16'(ready_zx), 16'(r));
        chk({tag, "_ovr_zx"},   16'(ovr_zx),   16'(o));
        chk({tag, "_busy_sx"},  16'(busy_sx),  16'(b));
        chk({tag, "_ready_sx"}, 16'(ready_sx), 16'(r));
        chk({tag, "_ovr_sx"},   16'(ovr_sx),   16'(o));
    endtask

    task automatic chk_z(input string tag);
        chk({tag, "_z_zx"}, fsmc_d_zx, 16'hzzzz);
        chk({tag, "_z_sx"}, fsmc_d_sx, 16'hzzzz);
    endtask

    // START edge; BUSY must rise exactly on the third DCLK edge.
    task automatic start_acq(input string tag, input logic busy_pre, input logic ovr_exp);
        START = 1'b1;
        tick(2);
        chk({tag, "_busy_pre_zx"}, 16'(busy_zx), 16'(busy_pre));
        chk({tag, "_busy_pre_sx"}, 16'(busy_sx), 16'(busy_pre));
        tick(1);
        chk_st({tag, "_go"}, 1'b1, 1'b0, ovr_exp);
        START = 1'b0;
        tick(2);
        q_zx.delete();
        q_sx.delete();
        q_zx.push_back(16'hA55A);
        q_sx.push_back(16'hA55A);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] c0, input logic [DATA_W-1:0] c1);
        SMP_DATA  = {c1, c0};
        SMP_VALID = 1'b1;
        q_zx.push_back(ext(c0, 1'b0));
        q_zx.push_back(ext(c1, 1'b0));
        q_sx.push_back(ext(c0, 1'b1));
        q_sx.push_back(ext(c1, 1'b1));
        tick(1);
        SMP_VALID = 1'b0;
        tick(1);
    endtask

    task automatic read_word(input string tag);
        logic [BUS_W-1:0] ez, es;
        FGPA_OE = 1'b0;
        tick(4);
        chk({tag, "_sb_avail"}, 16'(q_zx.size() > 0), 16'd1);
        ez = (q_zx.size() > 0) ? q_zx.pop_front() : 16'hDEAD;
        es = (q_sx.size() > 0) ? q_sx.pop_front() : 16'hDEAD;
        chk({tag, "_word_zx"}, fsmc_d_zx, ez);
        chk({tag, "_word_sx"}, fsmc_d_sx, es);
        FGPA_OE = 1'b1;
        tick(7);
    endtask

    task automatic oe_strobe_z(input string tag);
        FGPA_OE = 1'b0;
        tick(4);
        chk_z(tag);
        FGPA_OE = 1'b1;
        tick(7);
    endtask

    task automatic read_rest(input string tag, input logic ovr_exp);
        while (q_zx.size() > 0) read_word(tag);
        chk_st({tag, "_done"}, 1'b0, 1'b0, ovr_exp);
        chk({tag, "_drain"}, 16'(q_sx.size()), 16'd0);
        oe_strobe_z({tag, "_after"});
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        RST_N     = 1'b0;
        START     = 1'b0;
        SMP_VALID = 1'b0;
        SMP_DATA  = '0;
        FGPA_OE   = 1'b1;
        tick(3);

        // Reset state.
        chk_st("reset", 1'b0, 1'b0, 1'b0);
        FGPA_OE = 1'b0;
        tick(1);
        chk_z("reset");
        FGPA_OE = 1'b1;
        RST_N   = 1'b1;
        tick(2);
        oe_strobe_z("idle_oe");
        chk_st("idle_oe", 1'b0, 1'b0, 1'b0);

        // Basic capture and readout.
        start_acq("basic", 1'b0, 1'b0);
        send_frame(12'd1, 12'd2);
        send_frame(12'd3, 12'd4);
        send_frame(12'd5, 12'd6);
        chk("basic_ready_lo", 16'(ready_zx), 16'd0);
        SMP_DATA  = {12'd8, 12'd7};
        SMP_VALID = 1'b1;
        q_zx.push_back(16'd7); q_zx.push_back(16'd8);
        q_sx.push_back(16'd7); q_sx.push_back(16'd8);
        tick(1);
        SMP_VALID = 1'b0;
        chk_st("basic_ready_hi", 1'b1, 1'b1, 1'b0);
        tick(1);
        read_rest("basic", 1'b0);

        // Sign extension.
        start_acq("sign", 1'b0, 1'b0);
        send_frame(12'h800, 12'h7FF);
        send_frame(12'hFFF, 12'h000);
        send_frame(12'h123, 12'hABC);
        send_frame(12'h001, 12'h800);
        tick(1);
        read_rest("sign", 1'b0);

        // Ignored strobes, then restart during readout.
        start_acq("ign", 1'b0, 1'b0);
        send_frame(12'h011, 12'h022);
        oe_strobe_z("cap_oe");
        chk_st("cap_oe", 1'b1, 1'b0, 1'b0);
        send_frame(12'h033, 12'h044);
        send_frame(12'h055, 12'h066);
        send_frame(12'h077, 12'h088);
        SMP_DATA  = {12'hEEE, 12'hDDD};
        SMP_VALID = 1'b1;
        tick(1);
        SMP_VALID = 1'b0;
        tick(1);
        read_word("ign");
        read_word("ign");
        read_word("ign");
        start_acq("restart", 1'b1, 1'b1);
        send_frame(12'h101, 12'h102);
        send_frame(12'h103, 12'h104);
        send_frame(12'h105, 12'h106);
        send_frame(12'h107, 12'h108);
        tick(1);
        read_rest("restart", 1'b1);

        // START in IDLE clears OVERRUN; then START and SMP_VALID together.
        start_acq("clear", 1'b0, 1'b0);
        send_frame(12'h031, 12'h032);
        send_frame(12'h033, 12'h034);
        START = 1'b1;
        tick(2);
        SMP_DATA  = {12'h3EE, 12'h3DD};
        SMP_VALID = 1'b1;
        tick(1);
        SMP_VALID = 1'b0;
        START     = 1'b0;
        chk_st("simul", 1'b1, 1'b0, 1'b1);
        tick(2);
        q_zx.delete(); q_sx.delete();
        q_zx.push_back(16'hA55A); q_sx.push_back(16'hA55A);
        send_frame(12'h041, 12'h042);
        send_frame(12'h043, 12'h044);
        send_frame(12'h045, 12'h046);
        chk("simul_ready_lo", 16'(ready_zx), 16'd0);
        send_frame(12'h047, 12'h048);
        read_rest("simul", 1'b1);

        // Asynchronous reset mid-CAPTURE with OVERRUN set.
        start_acq("pre_ar", 1'b0, 1'b0);
        send_frame(12'h051, 12'h052);
        start_acq("ar_abort", 1'b1, 1'b1);
        send_frame(12'h061, 12'h062);
        FGPA_OE = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk_st("arst", 1'b0, 1'b0, 1'b0);
        chk_z("arst");
        FGPA_OE = 1'b1;
        tick(2);
        RST_N = 1'b1;
        tick(2);
        start_acq("post_ar", 1'b0, 1'b0);
        send_frame(12'h071, 12'h072);
        send_frame(12'h073, 12'h074);
        send_frame(12'h075, 12'h076);
        send_frame(12'h077, 12'h078);
        read_rest("post_ar", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
